// File: rtl/latch_bank_rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : latch_bank_rom_reader
// Purpose  : Maps CPU cartridge reads to SDRAM reads. The 0x8000-0xBFFF window
//            uses the latched bank and 0x4000-0x7FFF uses bank 0. A one-entry
//            read cache lets repeated fetches skip SDRAM.
// Revision : 1.0 - initial release
// ============================================================================
module latch_bank_rom_reader #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              cpu_rd,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        bank_latch,
  input  logic [ADDR_W-1:0] rom_base,
  input  logic [ADDR_W-1:0] rom_mask,
  input  logic              cache_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        cpu_data,
  output logic              cpu_wait
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam int         c_OFF_W = 22;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_rd_q;
  logic              w_window;
  logic              w_start;
  logic              w_hit;
  logic              w_fill;
  logic [7:0]        w_bank;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [7:0]        r_data;

  // Only the rising edge of cpu_rd in IDLE launches a transaction.
  assign w_window = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);
  assign w_start  = cs && cpu_rd && !r_rd_q && w_window && (r_state == c_IDLE);

  assign w_bank = (cpu_addr[15:14] == 2'b10) ? bank_latch : 8'h00;
  assign w_off  = {{(ADDR_W-c_OFF_W){1'b0}}, w_bank, cpu_addr[13:0]};
  assign w_addr = rom_base + (w_off & rom_mask);

  // The tag is the full SDRAM address, so bank switches never need a flush.
  assign w_hit  = r_valid && (r_tag == w_addr);
  assign w_fill = (r_state == c_REQ) && mem_ack;

  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (w_start) w_next = w_hit ? c_DONE : c_REQ;
      c_REQ:  if (mem_ack) w_next = cpu_rd ? c_DONE : c_IDLE;
      c_DONE: if (!cpu_rd) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    cpu_wait = w_start;
    cpu_data = 8'hFF;
    case (r_state)
      c_REQ: begin
        mem_req  = 1'b1;
        cpu_wait = 1'b1;
      end
      c_DONE: cpu_data = r_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_q     <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_rd_q <= cpu_rd;
      if (w_start) r_mem_addr <= w_addr;
    end
  end

  // A fill landing in the same cycle as a flush leaves the entry valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= 8'h00;
    end else if (w_fill) begin
      r_valid <= 1'b1;
      r_tag   <= r_mem_addr;
      r_data  <= mem_data;
    end else if (cache_flush) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_bank_rom_reader
// Purpose  : Directed and random reads against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_bank_rom_reader;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs;
  logic              cpu_rd;
  logic [15:0]       cpu_addr;
  logic [7:0]        bank_latch;
  logic [ADDR_W-1:0] rom_base;
  logic [ADDR_W-1:0] rom_mask;
  logic              cache_flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        cpu_data;
  logic              cpu_wait;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference cache contents
  logic              m_valid;
  logic [ADDR_W-1:0] m_tag;
  logic [7:0]        m_data;

  latch_bank_rom_reader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .bank_latch (bank_latch),
    .rom_base   (rom_base),
    .rom_mask   (rom_mask),
    .cache_flush(cache_flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .cpu_data   (cpu_data),
    .cpu_wait   (cpu_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // ROM offset = page * 16 KB + offset within the 16 KB window, masked then rebased.
  function automatic logic [ADDR_W-1:0] model_addr(input logic [15:0] a, input logic [7:0] b,
                                                    input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] mask);
    int unsigned page, off, sum;
    page = (a >= 16'h8000) ? 32'(b) : 0;
    off  = page * 16384 + 32'(a) % 16384;
    sum  = 32'(base) + (off & 32'(mask));
    return ADDR_W'(sum);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_ack     = 1'b0;
    cache_flush = 1'b0;
  endtask

  task automatic pulse_flush();
    next_cycle();
    cache_flush = 1'b1;
    m_valid     = 1'b0;
    #1;
  endtask

  // One CPU read. Miss options: ack after ack_n cycles, cpu_rd drop at abort_at,
  // bank rewrite on the first REQ cycle (chg_bank >= 0), flush at flush_at.
  task automatic do_read(input logic [15:0] a, input logic csv, input int ack_n,
                         input logic [7:0] d, input int abort_at, input int chg_bank,
                         input int flush_at);
    logic [ADDR_W-1:0] ea;
    logic st, hit, aborted;
    next_cycle();
    cs = csv; cpu_rd = 1'b1; cpu_addr = a;
    st  = csv && (a[15:14] == 2'b01 || a[15:14] == 2'b10);
    ea  = model_addr(a, bank_latch, rom_base, rom_mask);
    hit = m_valid && (m_tag == ea);
    #1;
    check("start_wait", 32'(cpu_wait), 32'(st));
    check("start_req", 32'(mem_req), 32'd0);
    if (!st) begin
      next_cycle(); #1;
      check("oow_data", 32'(cpu_data), 32'hFF);
      check("oow_wait", 32'(cpu_wait), 32'd0);
      check("oow_req", 32'(mem_req), 32'd0);
    end else if (hit) begin
      next_cycle(); #1;
      check("hit_data", 32'(cpu_data), 32'(m_data));
      check("hit_wait", 32'(cpu_wait), 32'd0);
      check("hit_req", 32'(mem_req), 32'd0);
      check("hit_addr", 32'(mem_addr), 32'(ea));
      next_cycle();
      cpu_rd = 1'b0; #1;
      check("hit_hold", 32'(cpu_data), 32'(m_data));
    end else begin
      aborted = 1'b0;
      for (int k = 1; k <= ack_n; k++) begin
        next_cycle();
        cpu_addr = 16'($urandom);
        cs       = 1'($urandom);
        if (chg_bank >= 0 && k == 1) bank_latch = 8'(chg_bank);
        if (k == abort_at) begin cpu_rd = 1'b0; aborted = 1'b1; end
        if (k == flush_at) begin cache_flush = 1'b1; m_valid = 1'b0; end
        if (k == ack_n) begin
          mem_ack = 1'b1; mem_data = d;
          m_valid = 1'b1; m_tag = ea; m_data = d;
        end
        #1;
        check("req_high", 32'(mem_req), 32'd1);
        check("req_addr", 32'(mem_addr), 32'(ea));
        check("req_wait", 32'(cpu_wait), 32'd1);
        check("req_data", 32'(cpu_data), 32'hFF);
      end
      next_cycle(); #1;
      if (aborted) begin
        check("abort_data", 32'(cpu_data), 32'hFF);
        check("abort_wait", 32'(cpu_wait), 32'd0);
        check("abort_req", 32'(mem_req), 32'd0);
      end else begin
        check("miss_data", 32'(cpu_data), 32'(d));
        check("miss_wait", 32'(cpu_wait), 32'd0);
        check("miss_req", 32'(mem_req), 32'd0);
        next_cycle();
        cpu_rd = 1'b0; #1;
      end
    end
    next_cycle();
    cpu_rd = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1; mem_data = 8'($urandom);
    end
    #1;
    check("idle_data", 32'(cpu_data), 32'hFF);
    check("idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [13:0] lo;
    int n, ab, fl;

    reset = 1'b1; cs = 1'b0; cpu_rd = 1'b0; cpu_addr = 16'h0; bank_latch = 8'h00;
    rom_base = '0; rom_mask = '0; cache_flush = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
    m_valid = 1'b0; m_tag = '0; m_data = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wait", 32'(cpu_wait), 32'd0);
    check("rst_data", 32'(cpu_data), 32'hFF);
    next_cycle();
    reset = 1'b0;

    // Basic bank read, mask wrap, fixed page
    rom_base = 25'h100000; rom_mask = 25'h1FFFF; bank_latch = 8'h03;
    do_read(16'h8123, 1'b1, 4, 8'h5A, 0, -1, 0);
    bank_latch = 8'h0B;
    do_read(16'h8123, 1'b1, 2, 8'hA5, 0, -1, 0);
    do_read(16'h4010, 1'b1, 3, 8'h10, 0, -1, 0);
    // Hit, then flush and miss again
    bank_latch = 8'h03;
    do_read(16'h8123, 1'b1, 2, 8'h5A, 0, -1, 0);
    do_read(16'h8123, 1'b1, 2, 8'h00, 0, -1, 0);
    pulse_flush();
    do_read(16'h8123, 1'b1, 2, 8'h5A, 0, -1, 0);
    // Out of window, cs low, bank rewrite mid-REQ
    do_read(16'h0010, 1'b1, 1, 8'h00, 0, -1, 0);
    do_read(16'h8000, 1'b0, 1, 8'h00, 0, -1, 0);
    bank_latch = 8'h01;
    do_read(16'h8000, 1'b1, 3, 8'h33, 0, 2, 0);
    // Abort, then the aborted fill serves as a hit
    pulse_flush();
    bank_latch = 8'h01;
    do_read(16'h8000, 1'b1, 5, 8'h77, 2, -1, 0);
    do_read(16'h8000, 1'b1, 1, 8'h00, 0, -1, 0);
    // Flush coinciding with fill
    do_read(16'h4000, 1'b1, 3, 8'hC3, 0, -1, 3);
    do_read(16'h4000, 1'b1, 1, 8'h00, 0, -1, 0);

    // Reset during REQ, late ack afterwards
    pulse_flush();
    next_cycle();
    cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h8000;
    next_cycle(); #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1; cpu_rd = 1'b0; #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_wait", 32'(cpu_wait), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    next_cycle(); next_cycle();
    reset = 1'b0;
    next_cycle();
    mem_ack = 1'b1; mem_data = 8'h99; #1;
    check("late_ack_req", 32'(mem_req), 32'd0);
    next_cycle(); #1;
    check("late_ack_data", 32'(cpu_data), 32'hFF);
    check("late_ack_req2", 32'(mem_req), 32'd0);
    m_valid = 1'b0;
    do_read(16'h8000, 1'b1, 2, 8'h44, 0, -1, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rom_base = ADDR_W'($urandom);
        rom_mask = ADDR_W'((1 << $urandom_range(15, 24)) - 1);
      end
      if ($urandom_range(0, 7) == 0) pulse_flush();
      bank_latch = 8'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       lo = 14'h0123;
        1:       lo = 14'h0000;
        default: lo = 14'h3FFF;
      endcase
      a  = {2'($urandom), lo};
      n  = $urandom_range(1, 5);
      ab = ($urandom_range(0, 6) == 0) ? $urandom_range(1, n) : 0;
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n) : 0;
      do_read(a, 1'($urandom_range(0, 9) != 0), n, 8'($urandom), ab,
              $urandom_range(0, 255), fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/latch_bank_rom_reader.md
# latch_bank_rom_reader

Cartridge ROM read engine that consumes the 8-bit bank value produced by the I/O latch-port device and turns CPU memory reads in the cartridge slot into SDRAM read transactions. It maps CPU window 0x8000–0xBFFF to a 16 KB bank selected by the latch value and maps 0x4000–0x7FFF to fixed bank 0. It sequences a req/ack handshake to the memory arbiter, stalls the CPU with a wait signal, and keeps a one-entry read cache so that repeated fetches of the same byte skip SDRAM.

## Interface
Parameters:
- ADDR_W, 25, SDRAM byte-address width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  cartridge slot selected for current memory cycle.
- cpu_rd  in  1  memory read strobe, level, held for whole CPU cycle.
- cpu_addr  in  16  CPU address.
- bank_latch  in  8  bank value from latch port device; 0x00 after its reset.
- rom_base  in  ADDR_W  SDRAM byte address of ROM image start.
- rom_mask  in  ADDR_W  ROM size minus 1; size is a power of two.
- cache_flush  in  1  single-cycle pulse; invalidates read cache.
- mem_req  out  1  SDRAM read request.
- mem_addr  out  ADDR_W  SDRAM byte address; stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  8  SDRAM read data.
- cpu_data  out  8  read data to CPU; 0xFF when not driving.
- cpu_wait  out  1  CPU stall.

## Operation
- rd_q registers cpu_rd; the start condition is cs && cpu_rd && !rd_q && cpu_addr[15:14] ∈ {01,10}.
- Offset: bank = (cpu_addr[15:14]==10) ? bank_latch : 8'h00. off = {bank, cpu_addr[13:0]} (22 bits, zero-extended to ADDR_W). addr = rom_base + (off & rom_mask), computed in ADDR_W bits; the carry out is discarded.
- The bank is sampled at the start condition. A latch change during a read affects only later reads.
- The cache holds one entry: valid, tag[ADDR_W], data[8]. The tag is the full SDRAM address, so a bank change does not require invalidation.
- FSM states:
  - IDLE. On start, register addr into mem_addr. If valid && tag==addr, go to DONE (hit). Otherwise go to REQ.
  - REQ. Hold mem_req=1. On mem_ack, capture mem_data into the cache (valid=1, tag=mem_addr). If cpu_rd is still high, go to DONE; otherwise go to IDLE (abort, no data presented).
  - DONE. Drive cpu_data from the cache. Return to IDLE when cpu_rd is low.
- cpu_wait = start || (state==REQ). It is combinational from start only in the first cycle.
- cpu_data = cache data in DONE, else 0xFF. Reads outside the window, or with cs low, return 0xFF and issue no request.
- cache_flush clears valid in any state. If it coincides with a mem_ack fill, the fill wins and valid=1.
- mem_req stays high until mem_ack, even if cpu_rd or cs drops. The handshake is never withdrawn.
- mem_ack outside REQ is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_addr 0, cpu_wait 0, cpu_data 0xFF, cache valid 0, rd_q 0.
- Reset mid-REQ drops mem_req immediately (asynchronously). A late mem_ack after reset is ignored.
- Cycle 0: start is detected and cpu_wait=1.
- Miss path:
  - mem_req=1 from cycle 1.
  - mem_ack arrives at cycle N (N≥1).
  - At N+1: DONE, mem_req=0, cpu_wait=0, cpu_data valid.
- Hit path: at cycle 1, DONE, cpu_wait=0, cpu_data valid. Hit latency is 1 cycle and no mem_req is issued.
- Back-to-back reads: a new start is only possible after cpu_rd has been low for at least one cycle (edge detect). After DONE, IDLE is reached one cycle after cpu_rd falls.
- cpu_addr, cs and bank_latch are sampled only in the start cycle.

## Test plan
- Basic bank read:
  - Stimulus: rom_base=0x100000, rom_mask=0x1FFFF, bank_latch=0x03, read 0x8123, ack after 4 cycles with 0x5A.
  - Required: mem_addr=0x10C123, mem_req high for 4 cycles, cpu_wait low the cycle after ack, cpu_data=0x5A.
- Mask wrap and fixed page:
  - Stimulus: bank_latch=0x0B, read 0x8123; then read 0x4010.
  - Required: mem_addr=0x10C123 (wrapped), then 0x100010.
- Cache hit and flush:
  - Stimulus: repeat read 0x8123 with bank 0x03; then pulse cache_flush and read again.
  - Required: the second read returns 0x5A at cycle 1 with no mem_req. After the flush, the read issues mem_req again.
- Out of window and bank change mid-read:
  - Stimulus: read 0x0010 with cs=1. Then start a read of 0x8000 with bank 0x01 and write bank 0x02 during REQ.
  - Required: the first read gives 0xFF, no mem_req, cpu_wait low. The second gives mem_addr=0x104000 throughout.
- Abort:
  - Stimulus: drop cpu_rd at cycle 2 of REQ, ack at cycle 5 with 0x77.
  - Required: mem_req held until ack, FSM goes to IDLE, cpu_data stays 0xFF, cache tag 0x104000 / data 0x77 valid.
- Reset mid-transaction:
  - Stimulus: assert reset during REQ, then ack one cycle after reset release.
  - Required: mem_req=0 immediately, cache invalid, ack ignored, FSM in IDLE.
